// File: rtl/binary_to_bcd_seq.sv
// rtl/binary_to_bcd_seq.sv - sequential double-dabble binary to BCD converter
module binary_to_bcd_seq #(
    parameter int DW   = 14,
    parameter int NDIG = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DW-1:0]     i_bin,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_ovf,
    output logic [4*NDIG-1:0] o_bcd
);

    localparam int SW = 4 * NDIG;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [DW-1:0]   bin_sr;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [CW-1:0]   cnt;
    logic            ovf_acc;

    // Add-3 correction so each digit carries cleanly into its neighbour on the shift.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < NDIG; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_ovf   <= 1'b0;
            o_bcd   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state   <= CONV;
                        bin_sr  <= i_bin;
                        scratch <= '0;
                        cnt     <= CW'(DW);
                        ovf_acc <= 1'b0;
                        o_busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CONV: begin
                    if (cnt != '0) begin
                        // A set top bit leaving the scratch means the value needs more than NDIG digits.
                        scratch <= {adj[SW-2:0], bin_sr[DW-1]};
                        bin_sr  <= {bin_sr[DW-2:0], 1'b0};
                        ovf_acc <= ovf_acc | adj[SW-1];
                        cnt     <= cnt - CW'(1);
                    end else begin
                        state  <= DONE;
                        o_bcd  <= scratch;
                        o_ovf  <= ovf_acc;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
